prio_scan_encoder: RTL

Parametrised, sequential priority encoder that accepts a one-hot-or-multi-hot request vector and emits the index of every set bit, one per handshake beat, in priority order. It is the next generation of the fixed 32-to-5 bus-select encoder. It generalises width and scan direction, defines an encoding for bit 0 and for an all-zero vector, and drains multi-bit vectors instead of reporting only the winner. It sits between request sources (register-select, interrupt/exception pending bits) and the consumer that services one index at a time.

---
 rtl/prio_scan_encoder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/prio_scan_encoder.sv
// Sequential priority encoder: captures a request vector and emits the index of
// every set bit, one per handshake beat, in priority order (zero vector -> one beat).
module prio_scan_encoder #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1,
  localparam int OUT_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none,
  output logic             busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Index of the highest-priority set bit; an empty vector encodes to 0.
  function automatic logic [OUT_W-1:0] prio_idx(input logic [WIDTH-1:0] v);
    logic [OUT_W-1:0] r;
    r = {OUT_W{1'b0}};
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (v[i]) begin
          r = OUT_W'(i);
        end else begin
          r = r;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (v[i]) begin
          r = OUT_W'(i);
        end else begin
          r = r;
        end
      end
    end
    return r;
  endfunction

  function automatic logic is_single(input logic [WIDTH-1:0] v);
    return (v != ZERO_V) && ((v & (v - ONE_V)) == ZERO_V);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pend_q,  pend_d;
  logic             zflag_q, zflag_d;
  // Index and last flag of the head beat, precomputed so outputs come from flops.
  logic [OUT_W-1:0] idx_q,   idx_d;
  logic             last_q,  last_d;

  // Next-state, pending-vector and head-beat computation.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zflag_d = zflag_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !abort) begin
          pend_d  = in_vec;
          zflag_d = (in_vec == ZERO_V);
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (abort) begin
          pend_d  = ZERO_V;
          zflag_d = 1'b0;
          state_d = IDLE;
        end else if (out_ready) begin
          pend_d = pend_q & ~(ONE_V << idx_q);
          if (last_q) begin
            zflag_d = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = SCAN;
          end
        end else begin
          state_d = SCAN;
        end
      end
      default: begin
        pend_d  = ZERO_V;
        zflag_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    idx_d  = prio_idx(pend_d);
    last_d = is_single(pend_d) | zflag_d;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= ZERO_V;
      zflag_q <= 1'b0;
      idx_q   <= {OUT_W{1'b0}};
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zflag_q <= zflag_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  // Outputs depend only on registered state and abort; beat fields are zero when idle.
  always_comb begin
    busy      = (state_q == SCAN);
    in_ready  = (state_q == IDLE) & ~abort;
    out_valid = (state_q == SCAN) & ~abort;
    if (out_valid) begin
      out_idx  = idx_q;
      out_last = last_q;
      out_none = zflag_q;
    end else begin
      out_idx  = {OUT_W{1'b0}};
      out_last = 1'b0;
      out_none = 1'b0;
    end
  end

endmodule
